// File: rtl/spi_temp_scanner_pkg.sv
// ---------------------------------------------------------------------------
// spi_temp_scanner_pkg: FSM state encoding and the frame-slice helper shared
// by the SPI temperature scanner.   Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package spi_temp_scanner_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_SHIFT = 3'd2,
    ST_HOLD  = 3'd3,
    ST_LATCH = 3'd4,
    ST_GAP   = 3'd5
  } state_t;

  // The temperature is the top TEMP_BITS of the frame; this is its LSB index.
  function automatic int frame_lsb(input int frame_bits, input int temp_bits);
    return frame_bits - temp_bits;
  endfunction

endpackage

`default_nettype wire

// File: rtl/spi_sck_gen.sv
// ---------------------------------------------------------------------------
// spi_sck_gen: SCK_DIV half-period divider; sck idles low, first toggle rises.
// rise/fall strobe the cycle before the edge that moves sck.   Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module spi_sck_gen #(
  parameter int SCK_DIV = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run,
  output logic sck,
  output logic rise,
  output logic fall
);

  localparam int CW = (SCK_DIV > 1) ? $clog2(SCK_DIV) : 1;

  logic [CW-1:0] cnt;
  logic          tick;

  assign tick = run && (cnt == CW'(SCK_DIV - 1));
  assign rise = tick && !sck;
  assign fall = tick && sck;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      sck <= 1'b0;
    end else if (!run) begin
      cnt <= '0;
      sck <= 1'b0;
    end else if (tick) begin
      cnt <= '0;
      sck <= ~sck;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/spi_temp_scanner.sv
// ---------------------------------------------------------------------------
// spi_temp_scanner: round-robin LM70-class SPI poller with per-channel latched
// temperatures. Define TEMP_ALARM_EN for hysteretic over-temp alarms. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module spi_temp_scanner
  import spi_temp_scanner_pkg::*;
#(
  parameter int NUM_CH     = 2,
  parameter int FRAME_BITS = 16,
  parameter int TEMP_BITS  = 9,
  parameter int SCK_DIV    = 2,
  parameter int GAP_CYCLES = 4
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              enable,
  output logic [NUM_CH-1:0]                 cs_n,
  output logic                              sck,
  input  logic                              sio,
  output logic [NUM_CH*TEMP_BITS-1:0]       temp_all,
  output logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0] temp_ch,
  output logic                              temp_valid,
  output logic                              busy
`ifdef TEMP_ALARM_EN
  ,
  input  logic [TEMP_BITS-1:0]              thresh_hi,
  input  logic [TEMP_BITS-1:0]              thresh_lo,
  output logic [NUM_CH-1:0]                 alarm
`endif
);

  localparam int CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int MAX_WAIT = (SCK_DIV > GAP_CYCLES) ? SCK_DIV : GAP_CYCLES;
  localparam int CNT_W    = $clog2(MAX_WAIT + 1);
  localparam int BIT_W    = $clog2(FRAME_BITS + 1);
  localparam int TEMP_LSB = frame_lsb(FRAME_BITS, TEMP_BITS);

  state_t                  state;
  state_t                  state_nx;
  logic [CNT_W-1:0]        cnt;
  logic [BIT_W-1:0]        falls;
  logic [FRAME_BITS-1:0]   shreg;
  logic [CH_W-1:0]         ch;
  logic [NUM_CH-1:0]       cs_nx;
  logic [TEMP_BITS-1:0]    temp_new;
  logic                    sck_rise;
  logic                    sck_fall;
  logic                    latch_now;

  spi_sck_gen #(
    .SCK_DIV (SCK_DIV)
  ) u_sck_gen (
    .clk   (clk),
    .rst_n (rst_n),
    .run   (state == ST_SHIFT),
    .sck   (sck),
    .rise  (sck_rise),
    .fall  (sck_fall)
  );

  assign busy      = (state != ST_IDLE);
  assign temp_new  = shreg[TEMP_LSB +: TEMP_BITS];
  assign latch_now = (state_nx == ST_LATCH);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    cs_nx    = '1;
    case (state)
      ST_IDLE:  if (enable) state_nx = ST_SETUP;
      ST_SETUP: if (cnt == CNT_W'(SCK_DIV - 1)) state_nx = ST_SHIFT;
      ST_SHIFT: if (sck_fall && (falls == BIT_W'(FRAME_BITS - 1))) state_nx = ST_HOLD;
      ST_HOLD:  if (cnt == CNT_W'(SCK_DIV - 1)) state_nx = ST_LATCH;
      ST_LATCH: state_nx = ST_GAP;
      ST_GAP:   if (cnt == CNT_W'(GAP_CYCLES - 1)) state_nx = enable ? ST_SETUP : ST_IDLE;
      default:  state_nx = ST_IDLE;
    endcase
    // chip select is registered from the next state so it moves with the edge
    if (state_nx == ST_SETUP || state_nx == ST_SHIFT || state_nx == ST_HOLD)
      cs_nx = ~(NUM_CH'(1) << ch);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cs_n  <= '1;
      cnt   <= '0;
      falls <= '0;
      shreg <= '0;
    end else begin
      cs_n <= cs_nx;
      if (state_nx != state)
        cnt <= '0;
      else if (state == ST_SETUP || state == ST_HOLD || state == ST_GAP)
        cnt <= cnt + 1'b1;
      if (state != ST_SHIFT)
        falls <= '0;
      else if (sck_fall)
        falls <= falls + 1'b1;
      if (sck_rise)
        shreg <= {shreg[FRAME_BITS-2:0], sio};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ch         <= '0;
      temp_all   <= '0;
      temp_ch    <= '0;
      temp_valid <= 1'b0;
    end else begin
      temp_valid <= latch_now;
      if (latch_now) begin
        temp_all[int'(ch)*TEMP_BITS +: TEMP_BITS] <= temp_new;
        temp_ch <= ch;
        ch      <= (ch == CH_W'(NUM_CH - 1)) ? '0 : ch + 1'b1;
      end
    end
  end

`ifdef TEMP_ALARM_EN
  logic al_set;
  logic al_clr;

  assign al_set = $signed(temp_new) > $signed(thresh_hi);
  assign al_clr = $signed(temp_new) < $signed(thresh_lo);

  // set has priority so an inverted threshold pair fails safe
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alarm <= '0;
    end else if (latch_now) begin
      if (al_set)      alarm[ch] <= 1'b1;
      else if (al_clr) alarm[ch] <= 1'b0;
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_spi_temp_scanner.sv
// ---------------------------------------------------------------------------
// tb_spi_temp_scanner: two scanner instances (2ch/SCK_DIV=2 and 3ch/SCK_DIV=1)
// against a frame-offset timing model and LM70 sensor models.   Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_spi_temp_scanner;

  localparam int FB  = 16;
  localparam int TBW = 9;
  localparam int N_A = 2, SD_A = 2, G_A = 4;
  localparam int N_B = 3, SD_B = 1, G_B = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, rst_n_b, en_a, en_b;
  logic [1:0]  cs_a;  logic sck_a, sio_a, val_a, busy_a;
  logic [17:0] tall_a; logic [0:0] tch_a;
  logic [2:0]  cs_b;  logic sck_b, sio_b, val_b, busy_b;
  logic [26:0] tall_b; logic [1:0] tch_b;
`ifdef TEMP_ALARM_EN
  logic [8:0] thi, tlo;
  logic [1:0] alarm_a;
  logic [2:0] alarm_b;
`endif

  spi_temp_scanner #(.NUM_CH(N_A), .FRAME_BITS(FB), .TEMP_BITS(TBW), .SCK_DIV(SD_A), .GAP_CYCLES(G_A)) dut_a (
    .clk(clk), .rst_n(rst_n), .enable(en_a), .cs_n(cs_a), .sck(sck_a), .sio(sio_a),
    .temp_all(tall_a), .temp_ch(tch_a), .temp_valid(val_a), .busy(busy_a)
`ifdef TEMP_ALARM_EN
    , .thresh_hi(thi), .thresh_lo(tlo), .alarm(alarm_a)
`endif
  );

  spi_temp_scanner #(.NUM_CH(N_B), .FRAME_BITS(FB), .TEMP_BITS(TBW), .SCK_DIV(SD_B), .GAP_CYCLES(G_B)) dut_b (
    .clk(clk), .rst_n(rst_n_b), .enable(en_b), .cs_n(cs_b), .sck(sck_b), .sio(sio_b),
    .temp_all(tall_b), .temp_ch(tch_b), .temp_valid(val_b), .busy(busy_b)
`ifdef TEMP_ALARM_EN
    , .thresh_hi(thi), .thresh_lo(tlo), .alarm(alarm_b)
`endif
  );

  int checks = 0;
  int fails  = 0;
  int cyc    = 0;
  bit done_b = 1'b0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- sensor models: word[inst][ch], MSB out first ----------------
  logic [15:0] word [2][3];
  int nr_a = 0, nr_b = 0, rises_b = 0;
  wire idle_a = &cs_a;
  wire idle_b = &cs_b;

  always @(posedge sck_a or posedge idle_a) if (idle_a) nr_a = 0; else nr_a = nr_a + 1;
  always @(posedge sck_b or posedge idle_b) if (idle_b) nr_b = 0; else nr_b = nr_b + 1;
  always @(posedge sck_b) rises_b = rises_b + 1;

  always_comb begin
    sio_a = 1'b0;
    for (int k = 0; k < N_A; k++) if (!cs_a[k] && nr_a < FB) sio_a = word[0][k][FB-1-nr_a];
  end
  always_comb begin
    sio_b = 1'b0;
    for (int k = 0; k < N_B; k++) if (!cs_b[k] && nr_b < FB) sio_b = word[1][k][FB-1-nr_b];
  end

  // ---------------- behavioural model: offset from the cs_n fall edge ----------------
  bit          m_run  [2];
  int          m_off  [2];
  int          m_ch   [2];
  int          m_tch  [2];
  bit          m_val  [2];
  logic [26:0] m_tall [2];
  logic [2:0]  m_alarm[2];

  task automatic model_reset(input int i);
    m_run[i] = 0; m_off[i] = 0; m_ch[i] = 0; m_tch[i] = 0; m_val[i] = 0;
    m_tall[i] = '0; m_alarm[i] = '0;
  endtask

  task automatic model_edge(input int i, input bit en, input int n, input int sd, input int g);
    int f;
    logic [TBW-1:0] t;
    f = sd * (2*FB + 2);
    m_val[i] = 0;
    if (m_run[i]) begin
      m_off[i]++;
      if (m_off[i] == f) begin
        t = word[i][m_ch[i]][FB-1 -: TBW];
        m_tall[i][m_ch[i]*TBW +: TBW] = t;
        m_tch[i] = m_ch[i];
        m_val[i] = 1;
`ifdef TEMP_ALARM_EN
        if ($signed(t) > $signed(thi))      m_alarm[i][m_ch[i]] = 1'b1;
        else if ($signed(t) < $signed(tlo)) m_alarm[i][m_ch[i]] = 1'b0;
`endif
        m_ch[i] = (m_ch[i] + 1) % n;
      end else if (m_off[i] == f + 1 + g) begin
        if (en) m_off[i] = 0;
        else    m_run[i] = 0;
      end
    end else if (en) begin
      m_run[i] = 1;
      m_off[i] = 0;
    end
  endtask

  always @(posedge clk or negedge rst_n)
    if (!rst_n) model_reset(0); else model_edge(0, en_a, N_A, SD_A, G_A);
  always @(posedge clk or negedge rst_n_b)
    if (!rst_n_b) model_reset(1); else model_edge(1, en_b, N_B, SD_B, G_B);

  function automatic logic [2:0] exp_cs(input int i, input int n, input int sd);
    logic [2:0] v;
    v = 3'((1 << n) - 1);
    if (m_run[i] && m_off[i] < sd * (2*FB + 2)) v[m_ch[i]] = 1'b0;
    return v;
  endfunction

  function automatic logic exp_sck(input int i, input int sd);
    int q;
    q = m_off[i] / sd;
    return m_run[i] && q >= 2 && q <= 2*FB && (q % 2) == 0;
  endfunction

  always @(negedge clk) begin
    check("cs_n_a",  cs_a,   exp_cs(0, N_A, SD_A));
    check("sck_a",   sck_a,  exp_sck(0, SD_A));
    check("valid_a", val_a,  m_val[0]);
    check("busy_a",  busy_a, m_run[0]);
    check("tall_a",  tall_a, m_tall[0]);
    check("tch_a",   tch_a,  m_tch[0]);
    check("cs_n_b",  cs_b,   exp_cs(1, N_B, SD_B));
    check("sck_b",   sck_b,  exp_sck(1, SD_B));
    check("valid_b", val_b,  m_val[1]);
    check("busy_b",  busy_b, m_run[1]);
    check("tall_b",  tall_b, m_tall[1]);
    check("tch_b",   tch_b,  m_tch[1]);
`ifdef TEMP_ALARM_EN
    check("alarm_a", alarm_a, m_alarm[0]);
    check("alarm_b", alarm_b, m_alarm[1]);
`endif
  end

  task automatic wait_valid(input int inst, input int budget, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < budget && !ok; k++) begin
      @(negedge clk);
      ok = (inst == 0) ? val_a : val_b;
    end
    if (!ok) begin
      checks++; fails++;
      $display("FAIL wait_valid%0d: got no temp_valid expected one within %0d cycles", inst, budget);
    end
  endtask

  // ---------------- instance B: 3 channels, SCK_DIV=1 ----------------
  initial begin : g_run_b
    logic [26:0] exp_tall [4];
    int exp_ch [4];
    int t_prev, r_prev;
    bit ok;
    exp_tall[0] = 27'h0000100; exp_tall[1] = 27'h0000300;
    exp_tall[2] = 27'h7FC0300; exp_tall[3] = 27'h7FC0202;
    exp_ch[0] = 0; exp_ch[1] = 1; exp_ch[2] = 2; exp_ch[3] = 0;
    word[1][0] = 16'h8000; word[1][1] = 16'h0080; word[1][2] = 16'hFF80;
    rst_n_b = 1'b0; en_b = 1'b0;
    repeat (3) @(negedge clk);
    rst_n_b = 1'b1; en_b = 1'b1;
    r_prev = rises_b; t_prev = 0;
    for (int k = 0; k < 4; k++) begin
      wait_valid(1, 120, ok);
      if (ok) begin
        check("b_order",  tch_b, exp_ch[k]);
        check("b_slots",  tall_b, exp_tall[k]);
        check("b_rises",  rises_b - r_prev, 16);
        if (k == 1) check("b_period", cyc - t_prev, 39);
        r_prev = rises_b; t_prev = cyc;
        if (k == 0) word[1][0] = 16'h0100;
      end
    end
    en_b = 1'b0;
    done_b = 1'b1;
  end

  // ---------------- instance A: default parameters ----------------
  initial begin : g_run_a
    int c0, c1, c2, nval, vch;
    bit ok;
    word[0][0] = 16'h0C80; word[0][1] = 16'hF380; word[0][2] = 16'h0000;
`ifdef TEMP_ALARM_EN
    thi = 9'd30; tlo = 9'd20;
`endif
    rst_n = 1'b0; en_a = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_cs_n", cs_a, 2'b11);
    check("rst_sck", sck_a, 1'b0);
    check("rst_temp_all", tall_a, 18'h0);
    check("rst_temp_ch", tch_a, 1'b0);
    check("rst_valid", val_a, 1'b0);
    check("rst_busy", busy_a, 1'b0);
    rst_n = 1'b1; en_a = 1'b1;
    @(posedge clk); #1;
    check("start_cs_n", cs_a, 2'b10);
    c0 = cyc;

    wait_valid(0, 200, ok);
    c1 = cyc;
    check("f0_ch", tch_a, 1'b0);
    check("f0_slot0", tall_a[8:0], 9'h019);
    check("f0_latency", c1 - c0, 68);
    wait_valid(0, 200, ok);
    c2 = cyc;
    check("f1_ch", tch_a, 1'b1);
    check("f1_slot1", tall_a[17:9], 9'h1E7);
    check("f1_slot0", tall_a[8:0], 9'h019);
    check("period", c2 - c1, 73);

    wait_valid(0, 200, ok);
    word[0][0] = 16'h7FFF; word[0][1] = 16'h8000;
    wait_valid(0, 200, ok);
    check("max_neg", tall_a[17:9], 9'h100);
    wait_valid(0, 200, ok);
    check("max_pos", tall_a[8:0], 9'h0FF);
    word[0][0] = 16'h0C80; word[0][1] = 16'hF380;

    // reset while the ch1 frame is shifting bit 7
    ok = 1'b0;
    for (int k = 0; k < 200 && !ok; k++) begin
      @(negedge clk);
      ok = (nr_a == 7);
    end
    check("reach_bit7", ok, 1'b1);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    check("arst_cs_n", cs_a, 2'b11);
    check("arst_sck", sck_a, 1'b0);
    check("arst_busy", busy_a, 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    wait_valid(0, 200, ok);
    check("post_rst_ch", tch_a, 1'b0);
    check("post_rst_slots", tall_a, 18'h00019);
    wait_valid(0, 200, ok);
    en_a = 1'b0;
    ok = 1'b0;
    for (int k = 0; k < 50 && !ok; k++) begin
      @(negedge clk);
      ok = !busy_a;
    end
    check("drain_idle", ok, 1'b1);

    // single-cycle enable pulse
    en_a = 1'b1;
    @(negedge clk);
    en_a = 1'b0;
    nval = 0; vch = 9;
    for (int k = 0; k < 150; k++) begin
      @(negedge clk);
      if (val_a) begin nval++; vch = tch_a; end
    end
    check("pulse_frames", nval, 1);
    check("pulse_ch", vch, 0);
    check("pulse_busy", busy_a, 1'b0);
    check("pulse_cs_n", cs_a, 2'b11);

`ifdef TEMP_ALARM_EN
    begin
      logic [15:0] seq [4];
      logic        al  [4];
      seq[0] = 16'h0C80; seq[1] = 16'h0F80; seq[2] = 16'h0C80; seq[3] = 16'h0980;
      al[0] = 1'b0; al[1] = 1'b1; al[2] = 1'b1; al[3] = 1'b0;
      word[0][0] = seq[0];
      en_a = 1'b1;
      for (int j = 0; j < 4; j++) begin
        ok = 1'b0;
        for (int k = 0; k < 400 && !ok; k++) begin
          @(negedge clk);
          ok = val_a && (tch_a == 1'b0);
        end
        check("alarm_seen", ok, 1'b1);
        check("alarm0", alarm_a[0], al[j]);
        if (j < 3) word[0][0] = seq[j+1];
      end
      en_a = 1'b0;
    end
`endif

    for (int k = 0; k < 2000 && !done_b; k++) @(negedge clk);
    check("b_done", done_b, 1'b1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule

`default_nettype wire
